// File: rtl/onchip_mem_read_master.sv
// rtl/onchip_mem_read_master.sv - Avalon-MM block read master with skid FIFO stream output
// Fetches cmd_len consecutive words from a fixed-latency slave and streams them out.
module onchip_mem_read_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 15,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        issue_left;
  logic [LEN_W-1:0]        pop_left;
  logic [CNT_W-1:0]        inflight;
  logic [READ_LATENCY-1:0] pipe;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          used;
  logic                    has_credit;
  logic                    cmd_fire, accept, push, pop;

  // Words buffered plus words still in the slave pipeline must fit the FIFO.
  assign used       = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit = used < (CNT_W+1)'(FIFO_DEPTH);

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign cmd_fire       = cmd_valid && cmd_ready;
  assign avm_read       = (state_q == ISSUE) && has_credit;
  assign avm_chipselect = avm_read;
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign accept         = avm_read && !avm_waitrequest;
  assign push           = pipe[READ_LATENCY-1];
  assign src_valid      = (fifo_count != '0);
  assign src_data       = fifo_mem[rd_ptr];
  assign src_last       = src_valid && (pop_left == LEN_W'(1));
  assign pop            = src_valid && src_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A zero-length command passes through DRAIN, which is trivially satisfied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd_fire) state_d = (cmd_len == '0) ? DRAIN : ISSUE;
      ISSUE: if (accept && issue_left == LEN_W'(1)) state_d = DRAIN;
      DRAIN: if (inflight == '0 && pop_left == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= '0;
      pipe       <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q     <= cmd_addr;
        issue_left <= cmd_len;
        pop_left   <= cmd_len;
      end else begin
        if (accept) begin
          addr_q     <= addr_q + ADDR_W'(1);
          issue_left <= issue_left - LEN_W'(1);
        end
        if (pop) pop_left <= pop_left - LEN_W'(1);
      end
      if (accept && !push)      inflight <= inflight + CNT_W'(1);
      else if (!accept && push) inflight <= inflight - CNT_W'(1);
      pipe[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers above.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm_readdata;
  end

endmodule

// File: tb/tb_onchip_mem_read_master.sv
// tb/tb_onchip_mem_read_master.sv - scoreboard bench for onchip_mem_read_master
// Directed commands against a latency-1 memory model; a negedge monitor checks the stream.
module tb_onchip_mem_read_master;

  localparam int AW = 14, DW = 32, LW = 15, RL = 1, FD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_read;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready = 1'b1;
  logic          src_last;

  onchip_mem_read_master #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .src_last(src_last)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  logic [32:0] exp_q [$];
  logic [AW-1:0] addr_log [$];

  int reads = 0, words = 0, dones = 0, sv_cycles = 0, nocredit = 0;
  int acc_cyc = 0, done_cyc = 0, first_sv_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1;
  int stall_at = -1, stall_left = 0, stalled = 0;
  logic [AW-1:0] stall_addr = '0;
  logic          hold = 1'b0, hold_last = 1'b0;
  logic [DW-1:0] hold_data = '0;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: fixed read latency of one cycle.
  always @(posedge clk)
    if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];

  always @(posedge clk) begin
    #1;
    src_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  always @(negedge clk) begin
    if (stall_left > 0 && avm_read && reads == stall_at) begin
      avm_waitrequest = 1'b1;
      stall_left--;
      stalled++;
      chk("stall_addr_held", avm_address, stall_addr);
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (avm_read && !avm_waitrequest) begin
      reads++;
      addr_log.push_back(avm_address);
    end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (done) begin dones++; done_cyc = cyc; end
    if (busy && dut.issue_left != '0 && !avm_read) nocredit++;
    if (dut.push) chk("fifo_overflow", (dut.fifo_count == FD && !dut.pop), 0);
    if (src_valid) begin
      sv_cycles++;
      if (first_sv_cyc < 0) first_sv_cyc = cyc;
    end
    if (hold && src_valid) begin
      chk("stall_data_stable", src_data, hold_data);
      chk("stall_last_stable", src_last, hold_last);
    end
    hold = src_valid && !src_ready;
    hold_data = src_data;
    hold_last = src_last;
    if (src_valid && src_ready) begin
      words++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("src_data", src_data, e[31:0]);
        chk("src_last", src_last, e[32]);
      end
    end
  end

  task automatic expect_word(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    first_sv_cyc = -1;
    first_pop_cyc = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    int d0, t;
    d0 = dones;
    start_cmd(a, n);
    t = 0;
    while (dones == d0 && t < 300) begin @(posedge clk); t++; end
    if (dones == d0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_avm_read"}, avm_read, 0);
    chk({tag, "_chipselect"}, avm_chipselect, 0);
    chk({tag, "_address"}, avm_address, 0);
    chk({tag, "_src_valid"}, src_valid, 0);
    chk({tag, "_src_last"}, src_last, 0);
  endtask

  initial begin
    int r0, w0, d0, a0, t;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hD000_0000 | i;
    mem[16'h10] = 32'h0000_00A0; mem[16'h11] = 32'h0000_00A1;
    mem[16'h12] = 32'h0000_00A2; mem[16'h13] = 32'h0000_00A3;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("byteenable", avm_byteenable, 4'hF);
    reset_n = 1'b1;

    // 1: basic block read, full throughput
    r0 = reads; w0 = words; d0 = dones;
    expect_word(32'h0000_00A0, 0); expect_word(32'h0000_00A1, 0);
    expect_word(32'h0000_00A2, 0); expect_word(32'h0000_00A3, 1);
    run_cmd(14'h0010, 15'd4);
    chk("t1_reads", reads - r0, 4);
    chk("t1_words", words - w0, 4);
    chk("t1_dones", dones - d0, 1);
    chk("t1_latency", first_sv_cyc - acc_cyc, 3);
    chk("t1_back_to_back", last_pop_cyc - first_pop_cyc, 3);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 2: backpressure 1-0-0-1, short then long enough to exhaust credit
    ready_mode = 1;
    r0 = reads; w0 = words; d0 = dones;
    expect_word(32'h0000_00A0, 0); expect_word(32'h0000_00A1, 0);
    expect_word(32'h0000_00A2, 0); expect_word(32'h0000_00A3, 1);
    run_cmd(14'h0010, 15'd4);
    chk("t2_reads", reads - r0, 4);
    chk("t2_words", words - w0, 4);
    chk("t2_dones", dones - d0, 1);
    r0 = reads; w0 = words; a0 = nocredit;
    for (int i = 0; i < 12; i++) expect_word(32'hD000_0040 + i, i == 11);
    run_cmd(14'h0040, 15'd12);
    chk("t2_long_reads", reads - r0, 12);
    chk("t2_long_words", words - w0, 12);
    chk("t2_credit_stall_seen", nocredit > a0, 1);
    chk("t2_sb_empty", exp_q.size(), 0);
    ready_mode = 0;

    // 3: zero-length command
    r0 = reads; w0 = sv_cycles; d0 = dones;
    run_cmd(14'h0010, 15'd0);
    chk("t3_reads", reads - r0, 0);
    chk("t3_src_valid_cycles", sv_cycles - w0, 0);
    chk("t3_dones", dones - d0, 1);
    chk("t3_done_latency", done_cyc - acc_cyc, 2);

    // 4: address wrap
    r0 = reads; a0 = addr_log.size();
    expect_word(32'hD000_3FFE, 0); expect_word(32'hD000_3FFF, 0);
    expect_word(32'hD000_0000, 0); expect_word(32'hD000_0001, 1);
    run_cmd(14'h3FFE, 15'd4);
    chk("t4_reads", reads - r0, 4);
    chk("t4_addr0", addr_log[a0],   14'h3FFE);
    chk("t4_addr1", addr_log[a0+1], 14'h3FFF);
    chk("t4_addr2", addr_log[a0+2], 14'h0000);
    chk("t4_addr3", addr_log[a0+3], 14'h0001);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: waitrequest for three cycles on the second read
    r0 = reads; w0 = words; t = stalled;
    stall_at = reads + 1; stall_left = 3; stall_addr = 14'h0031;
    for (int i = 0; i < 4; i++) expect_word(32'hD000_0030 + i, i == 3);
    run_cmd(14'h0030, 15'd4);
    chk("t5_stall_cycles", stalled - t, 3);
    chk("t5_reads", reads - r0, 4);
    chk("t5_words", words - w0, 4);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: reset mid-transfer, then a clean command
    w0 = words;
    for (int i = 0; i < 8; i++) expect_word(32'hD000_0050 + i, i == 7);
    start_cmd(14'h0050, 15'd8);
    t = 0;
    while (words - w0 < 2 && t < 100) begin @(negedge clk); t++; end
    chk("t6_two_words_before_reset", words - w0 >= 2, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t6_cmd_ready", cmd_ready, 1);
    r0 = reads; w0 = words; d0 = dones; a0 = addr_log.size();
    for (int i = 0; i < 3; i++) expect_word(32'hD000_0020 + i, i == 2);
    run_cmd(14'h0020, 15'd3);
    chk("t6_first_addr", addr_log[a0], 14'h0020);
    chk("t6_reads", reads - r0, 3);
    chk("t6_words", words - w0, 3);
    chk("t6_dones", dones - d0, 1);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
